hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage RV32I core.
- Drives stall, flush and forwarding selects for the F/D, D/E, E/M and M/W pipeline registers.
- Adds a registered data-memory wait-state FSM with a timeout, so a slow data memory freezes the back end of the pipeline until it acknowledges.
- Sits beside the datapath. Its outputs go directly to the enable and clear inputs of the stage registers.

---
 rtl/hazard_ctrl_pkg.sv | 17 +
 rtl/hazard_ctrl_fwd_sel.sv | 22 ++
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W_BITS = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } memState_t;

  localparam logic [FWD_W_BITS-1:0] FWD_RF = 2'b00;
  localparam logic [FWD_W_BITS-1:0] FWD_W  = 2'b01;
  localparam logic [FWD_W_BITS-1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding select for one Execute-stage source operand; M beats W, x0 never forwarded.
module fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0]      RsE,
  input  logic [REG_W-1:0]      RdM,
  input  logic [REG_W-1:0]      RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  output logic [FWD_W_BITS-1:0] ForwardE
);

  always_comb begin
    ForwardE = FWD_RF;
    if (RegWriteM && (RdM != '0) && (RdM == RsE)) begin
      ForwardE = FWD_M;
    end else if (RegWriteW && (RdW != '0) && (RdW == RsE)) begin
      ForwardE = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward control for the 5-stage core with a data-memory wait-state FSM.
// Optional stall/flush performance counters under HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = $clog2(MEM_TIMEOUT) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_W-1:0]      Rs1D,
  input  logic [REG_W-1:0]      Rs2D,
  input  logic [REG_W-1:0]      Rs1E,
  input  logic [REG_W-1:0]      Rs2E,
  input  logic [REG_W-1:0]      RdE,
  input  logic [REG_W-1:0]      RdM,
  input  logic [REG_W-1:0]      RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  ResultSrcE0,
  input  logic                  PCSrcE,
  input  logic                  MemReqM,
  input  logic                  MemReadyM,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic [FWD_W_BITS-1:0] ForwardAE,
  output logic [FWD_W_BITS-1:0] ForwardBE,
  output logic                  MemErr
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           StallCnt,
  output logic [31:0]           FlushCnt
`endif
);

  memState_t        state;
  memState_t        stateNext;
  logic [CNT_W-1:0] waitCnt;
  logic [CNT_W-1:0] waitCntNext;
  logic             memErrNext;
  logic             memStall;
  logic             lwStall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      waitCnt <= '0;
      MemErr  <= 1'b0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      MemErr  <= memErrNext;
    end
  end

  // Wait-state sequencing; MEM_ERR is only left through reset.
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    memErrNext  = MemErr;
    case (state)
      IDLE: begin
        if (MemReqM && !MemReadyM) begin
          stateNext   = MEM_WAIT;
          waitCntNext = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          stateNext   = IDLE;
          waitCntNext = '0;
        end else if (waitCnt == CNT_W'(MEM_TIMEOUT - 1)) begin
          stateNext  = MEM_ERR;
          memErrNext = 1'b1;
        end else begin
          waitCntNext = waitCnt + CNT_W'(1);
        end
      end
      MEM_ERR: begin
        memErrNext = 1'b1;
      end
      default: begin
        stateNext   = IDLE;
        waitCntNext = '0;
      end
    endcase
  end

  always_comb begin
    memStall = 1'b0;
    case (state)
      IDLE:     memStall = MemReqM && !MemReadyM;
      MEM_WAIT: memStall = !MemReadyM;
      MEM_ERR:  memStall = 1'b1;
      default:  memStall = 1'b0;
    endcase
  end

  assign lwStall = ResultSrcE0 && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));

  // memStall dominates: a frozen back end must not take bubbles from D/E.
  assign StallF = lwStall | memStall;
  assign StallD = lwStall | memStall;
  assign StallE = memStall;
  assign StallM = memStall;
  assign FlushW = memStall;
  assign FlushD = PCSrcE & ~memStall;
  assign FlushE = (lwStall | PCSrcE) & ~memStall;

  fwd_sel u_fwdA (
    .RsE      (Rs1E),
    .RdM      (RdM),
    .RdW      (RdW),
    .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW),
    .ForwardE (ForwardAE)
  );

  fwd_sel u_fwdB (
    .RsE      (Rs2E),
    .RdM      (RdM),
    .RdW      (RdW),
    .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW),
    .ForwardE (ForwardBE)
  );

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF) StallCnt <= StallCnt + 32'd1;
      if (FlushE) FlushCnt <= FlushCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4).
// Counter checks compile in only with HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCnt, FlushCnt;
`endif

  int nChecks = 0;
  int nErrors = 0;

  // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  logic [6:0] ctrl;
  assign ctrl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  localparam logic [6:0] CTRL_NONE = 7'b0000000;
  localparam logic [6:0] CTRL_LW   = 7'b1100010;
  localparam logic [6:0] CTRL_MEM  = 7'b1111001;
  localparam logic [6:0] CTRL_BR   = 7'b0000110;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemErr(MemErr)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic setIdle();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE0 = 1'b0; PCSrcE = 1'b0;
    MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    setIdle();
    reset = 1'b0;
    #2;
    checkVal("rst_ctrl", 32'(ctrl), 32'(CTRL_NONE));
    checkVal("rst_memerr", 32'(MemErr), 32'd0);
    checkVal("rst_fwd", 32'({ForwardAE, ForwardBE}), 32'd0);
    #10;
    reset = 1'b1;

    // Load-use hazard
    nextCycle();
    ResultSrcE0 = 1'b1; RdE = 5'd5; Rs1D = 5'd5; #1;
    checkVal("lw_rs1", 32'(ctrl), 32'(CTRL_LW));
    Rs1D = 5'd0; Rs2D = 5'd5; #1;
    checkVal("lw_rs2", 32'(ctrl), 32'(CTRL_LW));
    RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0; #1;
    checkVal("lw_x0", 32'(ctrl), 32'(CTRL_NONE));
    ResultSrcE0 = 1'b0; RdE = 5'd5; Rs1D = 5'd5; #1;
    checkVal("lw_notload", 32'(ctrl), 32'(CTRL_NONE));
    setIdle();

    // Forwarding priority and x0 suppression
    nextCycle();
    RegWriteM = 1'b1; RegWriteW = 1'b1; RdM = 5'd7; RdW = 5'd7; Rs1E = 5'd7; #1;
    checkVal("fwdA_m", 32'(ForwardAE), 32'b10);
    checkVal("fwdB_none", 32'(ForwardBE), 32'b00);
    RdM = 5'd0; #1;
    checkVal("fwdA_w", 32'(ForwardAE), 32'b01);
    Rs1E = 5'd0; RdW = 5'd0; #1;
    checkVal("fwdA_x0", 32'(ForwardAE), 32'b00);
    RdM = 5'd9; Rs2E = 5'd9; RdW = 5'd3; Rs1E = 5'd3; #1;
    checkVal("fwdB_m", 32'(ForwardBE), 32'b10);
    checkVal("fwdA_w2", 32'(ForwardAE), 32'b01);
    RegWriteM = 1'b0; #1;
    checkVal("fwdB_nowe", 32'(ForwardBE), 32'b00);
    setIdle();

    // Zero-wait access and stray ready
    nextCycle();
    MemReqM = 1'b1; MemReadyM = 1'b1; #1;
    checkVal("zw_same", 32'(ctrl), 32'(CTRL_NONE));
    nextCycle();
    MemReqM = 1'b0; MemReadyM = 1'b1; #1;
    checkVal("zw_next", 32'(ctrl), 32'(CTRL_NONE));
    nextCycle();
    MemReadyM = 1'b0; #1;
    checkVal("stray_rdy", 32'(ctrl), 32'(CTRL_NONE));

    // Three-cycle memory wait
    nextCycle();
    MemReqM = 1'b1; MemReadyM = 1'b0; #1;
    checkVal("mw_c1", 32'(ctrl), 32'(CTRL_MEM));
    nextCycle(); checkVal("mw_c2", 32'(ctrl), 32'(CTRL_MEM));
    nextCycle(); checkVal("mw_c3", 32'(ctrl), 32'(CTRL_MEM));
    nextCycle();
    MemReadyM = 1'b1; #1;
    checkVal("mw_rel", 32'(ctrl), 32'(CTRL_NONE));
    nextCycle();
    MemReqM = 1'b0; MemReadyM = 1'b0; #1;
    checkVal("mw_after", 32'(ctrl), 32'(CTRL_NONE));
    checkVal("mw_noerr", 32'(MemErr), 32'd0);

    // Branch resolved while the back end is frozen
    nextCycle();
    PCSrcE = 1'b1; MemReqM = 1'b1; MemReadyM = 1'b0; #1;
    checkVal("br_w1", 32'(ctrl), 32'(CTRL_MEM));
    nextCycle(); checkVal("br_w2", 32'(ctrl), 32'(CTRL_MEM));
    nextCycle();
    MemReadyM = 1'b1; #1;
    checkVal("br_rel", 32'(ctrl), 32'(CTRL_BR));
    nextCycle();
    setIdle(); #1;
    checkVal("br_done", 32'(ctrl), 32'(CTRL_NONE));

    // Reset abandons a wait in progress
    nextCycle();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    nextCycle();
    checkVal("rw_wait", 32'(ctrl), 32'(CTRL_MEM));
    pulseReset();
    MemReqM = 1'b0; #1;
    checkVal("rw_idle", 32'(ctrl), 32'(CTRL_NONE));

    // Timeout into sticky error
    nextCycle();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    nextCycle(); nextCycle(); nextCycle();
    checkVal("to_before", 32'(MemErr), 32'd0);
    nextCycle();
    checkVal("to_err", 32'(MemErr), 32'd1);
    checkVal("to_stall", 32'(ctrl), 32'(CTRL_MEM));
    MemReqM = 1'b0; MemReadyM = 1'b1;
    nextCycle(); nextCycle();
    checkVal("to_sticky", 32'(MemErr), 32'd1);
    checkVal("to_stall2", 32'(ctrl), 32'(CTRL_MEM));
    #1;
    reset = 1'b0; #1;
    checkVal("to_rst_err", 32'(MemErr), 32'd0);
    checkVal("to_rst_ctrl", 32'(ctrl), 32'(CTRL_NONE));
    reset = 1'b1;
    setIdle();

`ifdef HAZARD_PERF_CNT_EN
    nextCycle();
    pulseReset(); #1;
    checkVal("pc_rst", StallCnt, 32'd0);
    ResultSrcE0 = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
    nextCycle(); nextCycle(); nextCycle();
    setIdle();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    nextCycle(); nextCycle();
    MemReadyM = 1'b1;
    nextCycle();
    setIdle(); #1;
    checkVal("pc_stall", StallCnt, 32'd5);
    checkVal("pc_flush_lw", FlushCnt, 32'd3);
    pulseReset();
    PCSrcE = 1'b1;
    nextCycle();
    setIdle();
    nextCycle();
    checkVal("pc_flush_br", FlushCnt, 32'd1);
    checkVal("pc_stall_br", StallCnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
